pipe_ctrl: RTL and testbench

//  Hazard and sequencing controller for the 4-stage inst/reg/func/data pipeline.

---
 rtl/h2bp_pkg.sv | 11 +
 rtl/pipe_ctrl_if.sv | 45 ++++
 rtl/pipe_ctrl_sat_counter.sv | 18 +
 rtl/pipe_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_ctrl.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/h2bp_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
package h2bp;

    typedef enum logic [1:0] {
        PC_RUN,
        PC_LD_STALL,
        PC_MC_WAIT,
        PC_MC_RELEASE
    } pipe_ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard-controller bundle: the pipeline is the master, pipe_ctrl is the slave.
interface pipe_ctrl_if
    import h2bp::*;
#(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic [ADDR_W-1:0] rs_a_addr;
    logic              rs_a_en;
    logic [ADDR_W-1:0] rs_b_addr;
    logic              rs_b_en;
    logic              func_is_load;
    logic [ADDR_W-1:0] func_rd_addr;
    logic              func_rd_en;
    logic              func_branch;
    logic              mc_start;
    logic              mc_done;

    logic              pc_hold;
    logic              inst_hold;
    logic              bubble_func;
    logic              flush;
    logic              mc_go;
    logic              mc_abort;
    logic              mc_error;
    pipe_ctrl_state_e  state;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output rs_a_addr, rs_a_en, rs_b_addr, rs_b_en,
               func_is_load, func_rd_addr, func_rd_en, func_branch,
               mc_start, mc_done,
        input  pc_hold, inst_hold, bubble_func, flush, mc_go, mc_abort,
               mc_error, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  rs_a_addr, rs_a_en, rs_b_addr, rs_b_en,
               func_is_load, func_rd_addr, func_rd_en, func_branch,
               mc_start, mc_done,
        output pc_hold, inst_hold, bubble_func, flush, mc_go, mc_abort,
               mc_error, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Load-use / multi-cycle hazard controller: drives PC hold, reg-stage hold,
// func bubble, branch flush, multi-cycle launch/abort and perf counters.
module pipe_ctrl
    import h2bp::*;
#(
    parameter int ADDR_W     = 5,
    parameter int LD_STALL   = 2,
    parameter int MC_TIMEOUT = 16,
    parameter int CNT_W      = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    pipe_ctrl_if.slave bus
);

    localparam int LD_W = $clog2(LD_STALL + 1);
    localparam int WD_W = $clog2(MC_TIMEOUT);
    localparam logic [LD_W-1:0] LD_INIT = LD_W'(LD_STALL - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_TIMEOUT - 1);

    pipe_ctrl_state_e  state_q, state_d;
    logic [LD_W-1:0]   ld_q, ld_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              err_q, set_err;
    logic              hold, flush, go, abort, hz;
    logic [ADDR_W-1:0] rd;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    assign rd = bus.func_rd_addr;
    assign hz = bus.func_is_load && bus.func_rd_en && (rd != '0) &&
                ((bus.rs_a_en && (bus.rs_a_addr == rd)) ||
                 (bus.rs_b_en && (bus.rs_b_addr == rd)));

    // Outputs are gated by rst_n so nothing leaks out while in reset.
    always_comb begin
        state_d = state_q;
        ld_d    = ld_q;
        wd_d    = wd_q;
        set_err = 1'b0;
        hold    = 1'b0;
        flush   = 1'b0;
        go      = 1'b0;
        abort   = 1'b0;
        if (rst_n) begin
            if (bus.func_branch) begin
                flush   = 1'b1;
                abort   = (state_q == PC_MC_WAIT);
                state_d = PC_RUN;
                ld_d    = '0;
            end else begin
                case (state_q)
                    PC_RUN: begin
                        if (hz) begin
                            hold = 1'b1;
                            if (LD_STALL > 1) begin
                                state_d = PC_LD_STALL;
                                ld_d    = LD_INIT;
                            end
                        end else if (bus.mc_start) begin
                            hold    = 1'b1;
                            go      = 1'b1;
                            state_d = PC_MC_WAIT;
                            wd_d    = '0;
                        end
                    end
                    PC_LD_STALL: begin
                        hold = 1'b1;
                        ld_d = ld_q - LD_W'(1);
                        if (ld_q == LD_W'(1))
                            state_d = PC_RUN;
                    end
                    PC_MC_WAIT: begin
                        hold = 1'b1;
                        wd_d = wd_q + WD_W'(1);
                        if (bus.mc_done) begin
                            state_d = PC_MC_RELEASE;
                        end else if (wd_q == WD_LAST) begin
                            set_err = 1'b1;
                            abort   = 1'b1;
                            state_d = PC_MC_RELEASE;
                        end
                    end
                    default: state_d = PC_RUN;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PC_RUN;
            ld_q    <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ld_q    <= ld_d;
            wd_q    <= wd_d;
            err_q   <= err_q | set_err;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (hold),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush),
        .count (flush_cnt)
    );

    assign bus.pc_hold     = hold;
    assign bus.inst_hold   = hold;
    assign bus.bubble_func = hold;
    assign bus.flush       = flush;
    assign bus.mc_go       = go;
    assign bus.mc_abort    = abort;
    assign bus.mc_error    = err_q;
    assign bus.state       = state_q;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.flush_cnt   = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// traffic checked every cycle against a behavioural model.
module tb_pipe_ctrl;
    import h2bp::*;

    localparam int ADDR_W     = 5;
    localparam int LD_STALL   = 2;
    localparam int MC_TIMEOUT = 16;
    localparam int CNT_W      = 6;
    localparam int CMAX       = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    pipe_ctrl_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    pipe_ctrl #(
        .ADDR_W(ADDR_W), .LD_STALL(LD_STALL), .MC_TIMEOUT(MC_TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] outs;
    assign outs = {bus.pc_hold, bus.inst_hold, bus.bubble_func, bus.flush,
                   bus.mc_go, bus.mc_abort, bus.mc_error};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: dut=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase 0 run, 1 load stall, 2 mc wait, 3 mc release.
    int ph, stall_left, waited, e_stall, e_flush;
    bit e_err;
    always @(negedge clk) begin
        bit hz, hold, fl, go, ab, set_err;
        int nph;
        if (!rst_n) begin
            ph = 0; stall_left = 0; waited = 0; e_stall = 0; e_flush = 0; e_err = 0;
            chk("m_rst_outs", 32'(outs), 0);
            chk("m_rst_state", 32'(bus.state), 0);
            chk("m_rst_cnts", {bus.stall_cnt, bus.flush_cnt}, 0);
        end else begin
            chk("m_state", 32'(bus.state), ph);
            chk("m_stall_cnt", 32'(bus.stall_cnt), e_stall);
            chk("m_flush_cnt", 32'(bus.flush_cnt), e_flush);
            hz = bus.func_is_load && bus.func_rd_en && bus.func_rd_addr != 0 &&
                 ((bus.rs_a_en && bus.rs_a_addr == bus.func_rd_addr) ||
                  (bus.rs_b_en && bus.rs_b_addr == bus.func_rd_addr));
            hold = 0; fl = 0; go = 0; ab = 0; set_err = 0; nph = ph;
            if (bus.func_branch) begin
                fl = 1; ab = (ph == 2); nph = 0; stall_left = 0;
            end else if (ph == 1) begin
                hold = 1; stall_left--;
                if (stall_left == 0) nph = 0;
            end else if (ph == 2) begin
                hold = 1;
                if (bus.mc_done) nph = 3;
                else if (waited == MC_TIMEOUT - 1) begin ab = 1; set_err = 1; nph = 3; end
                waited++;
            end else if (ph == 3) begin
                nph = 0;
            end else if (hz) begin
                hold = 1; stall_left = LD_STALL - 1;
                if (stall_left > 0) nph = 1;
            end else if (bus.mc_start) begin
                hold = 1; go = 1; waited = 0; nph = 2;
            end
            chk("m_outs", 32'(outs), {hold, hold, hold, fl, go, ab, e_err});
            ph = nph;
            e_err = e_err | set_err;
            if (hold && e_stall < CMAX) e_stall++;
            if (fl && e_flush < CMAX) e_flush++;
        end
    end

    task automatic idle();
        bus.rs_a_addr = '0; bus.rs_a_en = 0; bus.rs_b_addr = '0; bus.rs_b_en = 0;
        bus.func_is_load = 0; bus.func_rd_addr = '0; bus.func_rd_en = 0;
        bus.func_branch = 0; bus.mc_start = 0; bus.mc_done = 0;
    endtask

    task automatic rand_in();
        bus.rs_a_addr    = ADDR_W'($urandom_range(3));
        bus.rs_a_en      = 1'($urandom_range(1));
        bus.rs_b_addr    = ADDR_W'($urandom_range(3));
        bus.rs_b_en      = 1'($urandom_range(1));
        bus.func_is_load = 1'($urandom_range(1));
        bus.func_rd_addr = ADDR_W'($urandom_range(3));
        bus.func_rd_en   = ($urandom_range(3) != 0);
        bus.func_branch  = ($urandom_range(9) == 0);
        bus.mc_start     = ($urandom_range(3) == 0);
        bus.mc_done      = ($urandom_range(5) == 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input string name, input logic [6:0] eo, input int est);
        #2;
        chk({name, "_outs"}, 32'(outs), 32'(eo));
        chk({name, "_state"}, 32'(bus.state), est);
    endtask

    task automatic do_reset();
        rst_n = 0; idle(); tick(); rst_n = 1;
    endtask

    task automatic set_load_hz(input int rd);
        bus.func_is_load = 1; bus.func_rd_en = 1;
        bus.func_rd_addr = ADDR_W'(rd); bus.rs_a_addr = ADDR_W'(rd); bus.rs_a_en = 1;
    endtask

    localparam logic [6:0] O_NONE  = 7'b0000000;
    localparam logic [6:0] O_HOLD  = 7'b1110000;
    localparam logic [6:0] O_GO    = 7'b1110100;
    localparam logic [6:0] O_TOUT  = 7'b1110010;
    localparam logic [6:0] O_ERR   = 7'b0000001;
    localparam logic [6:0] O_FL    = 7'b0001000;
    localparam logic [6:0] O_FL_AB = 7'b0001010;

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 0; idle();
        tick();
        // reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            rand_in();
            expect_cyc("rst", O_NONE, PC_RUN);
            tick();
        end
        idle(); rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            expect_cyc("post_rst", O_NONE, PC_RUN);
            tick();
        end

        // load-use stall
        do_reset();
        set_load_hz(5);
        expect_cyc("ld0", O_HOLD, PC_RUN); tick();
        expect_cyc("ld1", O_HOLD, PC_LD_STALL); tick();
        idle();
        expect_cyc("ld2", O_NONE, PC_RUN);
        chk("ld_stall_cnt", 32'(bus.stall_cnt), 2);
        set_load_hz(0);
        expect_cyc("ld_r0", O_NONE, PC_RUN); tick();
        chk("ld_r0_cnt", 32'(bus.stall_cnt), 2);
        idle();

        // multi-cycle op completing on wait cycle 3
        do_reset();
        bus.mc_start = 1;
        expect_cyc("mc0", O_GO, PC_RUN); tick();
        bus.mc_start = 0;
        expect_cyc("mc1", O_HOLD, PC_MC_WAIT); tick();
        expect_cyc("mc2", O_HOLD, PC_MC_WAIT); tick();
        bus.mc_done = 1;
        expect_cyc("mc3", O_HOLD, PC_MC_WAIT); tick();
        bus.mc_done = 0; bus.mc_start = 1;
        expect_cyc("mc_rel", O_NONE, PC_MC_RELEASE); tick();
        bus.mc_start = 0;
        expect_cyc("mc_run", O_NONE, PC_RUN);
        chk("mc_stall_cnt", 32'(bus.stall_cnt), 4);
        tick();

        // watchdog
        do_reset();
        bus.mc_start = 1;
        expect_cyc("wd_go", O_GO, PC_RUN); tick();
        bus.mc_start = 0;
        for (int w = 0; w < MC_TIMEOUT; w++) begin
            expect_cyc("wd_wait", (w == MC_TIMEOUT - 1) ? O_TOUT : O_HOLD, PC_MC_WAIT);
            tick();
        end
        expect_cyc("wd_rel", O_ERR, PC_MC_RELEASE); tick();
        for (int i = 0; i < 4; i++) begin
            expect_cyc("wd_sticky", O_ERR, PC_RUN); tick();
        end
        do_reset();
        expect_cyc("wd_clr", O_NONE, PC_RUN); tick();

        // branch during load stall
        do_reset();
        set_load_hz(7); tick();
        bus.func_branch = 1;
        expect_cyc("br_ld", O_FL, PC_LD_STALL); tick();
        idle();
        expect_cyc("br_ld_nx", O_NONE, PC_RUN);
        chk("br_ld_fcnt", 32'(bus.flush_cnt), 1);
        chk("br_ld_scnt", 32'(bus.stall_cnt), 1);
        // branch during mc wait
        bus.mc_start = 1; tick();
        bus.mc_start = 0; tick();
        bus.func_branch = 1;
        expect_cyc("br_mc", O_FL_AB, PC_MC_WAIT); tick();
        idle();
        expect_cyc("br_mc_nx", O_NONE, PC_RUN);
        chk("br_mc_fcnt", 32'(bus.flush_cnt), 2);
        tick();

        // branch + hazard + mc_start together
        do_reset();
        set_load_hz(3); bus.mc_start = 1; bus.func_branch = 1;
        expect_cyc("all3", O_FL, PC_RUN); tick();
        idle();
        expect_cyc("all3_nx", O_NONE, PC_RUN); tick();

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(399) != 0);
            rand_in();
            tick();
        end
        rst_n = 1;

        // counter saturation
        do_reset(); idle();
        set_load_hz(9);
        repeat (CMAX + 8) tick();
        chk("sat_stall", 32'(bus.stall_cnt), CMAX);
        idle(); bus.func_branch = 1;
        repeat (CMAX + 8) tick();
        chk("sat_flush", 32'(bus.flush_cnt), CMAX);
        chk("sat_stall_hold", 32'(bus.stall_cnt), CMAX);
        idle(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
